// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp tile board and its control FSM.
package chimp_pkg;

  localparam int unsigned NUM_W      = 6;
  localparam logic [NUM_W-1:0] NUM_EMPTY  = '0;
  localparam logic [NUM_W-1:0] NUM_MASKED = 6'd63;
  localparam int unsigned MAX_TILES  = 31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_PROBE,
    S_WRITE
  } place_state_e;

endpackage

// File: rtl/chimp_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, loaded with SEED on reset.
module chimp_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/chimp_tile_board.sv
// Chimp game board store: random tile placement, select-to-press pulse, registered drawer read port.
// Optional `CHIMP_BOARD_MASK_EN: after tile 1 is pressed, nonzero cells read back as the blank code.
module chimp_tile_board
  import chimp_pkg::*;
#(
  parameter int unsigned GRID_COLS = 8,
  parameter int unsigned GRID_ROWS = 4,
  parameter int unsigned MAX_TILES = chimp_pkg::MAX_TILES,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             iResetn,
  input  logic             iClear,
  input  logic             iPlace,
  input  logic             iSelect,
  input  logic [4:0]       iCursor,
  input  logic [4:0]       iRdCell,
  output logic [NUM_W-1:0] oRdNum,
  output logic [NUM_W-1:0] oPressNum,
  output logic             oPlaceDone,
  output logic             oBusy,
  output logic [4:0]       oTileCount,
  output logic             oFull
);

  localparam int unsigned NCELLS = GRID_COLS * GRID_ROWS;
  localparam int unsigned CIDX_W = $clog2(NCELLS);
  localparam int unsigned CELL_W = NUM_W - 1;

  place_state_e      state, nxt;
  logic [CIDX_W-1:0] cand;
  logic [15:0]       lfsr;
  logic [CELL_W-1:0] cells [NCELLS];
  logic [CELL_W-1:0] count;
  logic [NUM_W-1:0]  press_q;
  logic [NUM_W-1:0]  rd_q;
  logic [NUM_W-1:0]  rd_raw;
  logic [NUM_W-1:0]  rd_view;
  logic [CIDX_W-1:0] cur_idx;
  logic [CIDX_W-1:0] rd_idx;
  logic              cursor_ok;
  logic              full;
  logic              take_place;
  logic              sel_ok;
  logic              cand_free;
  logic              wr_place;
  logic              lfsr_unused;

  chimp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (iResetn),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:CIDX_W];

  assign cur_idx = iCursor[CIDX_W-1:0];
  assign rd_idx  = iRdCell[CIDX_W-1:0];

  // A 5-bit cursor cannot exceed a 32-cell board; smaller boards need the range test.
  if (CIDX_W >= 5) begin : g_cur_full
    assign cursor_ok = 1'b1;
  end else begin : g_cur_chk
    assign cursor_ok = ~|iCursor[4:CIDX_W];
  end

  assign full       = (count == CELL_W'(MAX_TILES));
  assign take_place = (state == S_IDLE) && iPlace && !full;
  assign sel_ok     = (state == S_IDLE) && iSelect && !take_place && cursor_ok;
  assign cand_free  = (cells[cand] == '0);
  assign wr_place   = (state == S_WRITE) && !iClear;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state <= S_IDLE;
      cand  <= '0;
    end else begin
      state <= nxt;
      if (state == S_PICK) begin
        cand <= lfsr[CIDX_W-1:0];
      end else if (state == S_PROBE && !cand_free) begin
        cand <= cand + 1'b1;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (take_place) nxt = S_PICK;
      S_PICK:  nxt = S_PROBE;
      S_PROBE: if (cand_free) nxt = S_WRITE;
      S_WRITE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (iClear) nxt = S_IDLE;
  end

  // Select only happens in IDLE and placement writes only in WRITE, so the two never collide.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      for (int unsigned i = 0; i < NCELLS; i++) cells[i] <= '0;
      count   <= '0;
      press_q <= '0;
    end else if (iClear) begin
      for (int unsigned i = 0; i < NCELLS; i++) cells[i] <= '0;
      count   <= '0;
      press_q <= '0;
    end else begin
      press_q <= '0;
      if (sel_ok) begin
        press_q        <= {1'b0, cells[cur_idx]};
        cells[cur_idx] <= '0;
      end
      if (wr_place) begin
        cells[cand] <= count + 1'b1;
        count       <= count + 1'b1;
      end
    end
  end

  assign rd_raw = {1'b0, cells[rd_idx]};

`ifdef CHIMP_BOARD_MASK_EN
  logic masked;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      masked <= 1'b0;
    end else if (iClear) begin
      masked <= 1'b0;
    end else if (press_q == NUM_W'(1)) begin
      masked <= 1'b1;
    end
  end

  assign rd_view = (masked && rd_raw != NUM_EMPTY) ? NUM_MASKED : rd_raw;
`else
  assign rd_view = rd_raw;
`endif

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_view;
    end
  end

  assign oRdNum     = rd_q;
  assign oPressNum  = press_q;
  assign oPlaceDone = wr_place;
  assign oBusy      = (state != S_IDLE);
  assign oTileCount = count;
  assign oFull      = full;

endmodule

// File: doc/chimp_tile_board.md
Name: chimp_tile_board

Overview:
- Board store directly upstream of the chimp game control FSM.
- Holds which tile number, if any, occupies each grid cell.
- Places tiles 1..N at pseudo-random free cells on request.
- Turns a player's cell selection into the one-cycle 6-bit pressed-number pulse the control FSM consumes, and gives the VGA drawer a registered per-cell read port.

Parameters:
- GRID_COLS, 8, cells per row.
- GRID_ROWS, 4, rows; NCELLS = GRID_COLS*GRID_ROWS; NCELLS must be a power of two and at least MAX_TILES+1.
- MAX_TILES, 31, highest tile number placeable.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- iResetn  in  1  reset; asynchronous, active-low.
- iClear  in  1  synchronous board wipe, one-cycle pulse.
- iPlace  in  1  pulse: place next tile number.
- iSelect  in  1  pulse: player pressed the cell at iCursor.
- iCursor  in  5  selected cell index (row*GRID_COLS+col).
- iRdCell  in  5  drawer read address.
- oRdNum  out  6  number at iRdCell, registered, 1-cycle latency; 0 = empty.
- oPressNum  out  6  one-cycle pulse of the selected tile number; 0 otherwise.
- oPlaceDone  out  1  one-cycle pulse when a placement completes.
- oBusy  out  1  high while the placement FSM is not in IDLE.
- oTileCount  out  5  number of tiles placed since the last clear.
- oFull  out  1  high when oTileCount == MAX_TILES.

Behaviour:
- Reset (iResetn low, asynchronous):
  - All cells are 0, count is 0, FSM is in IDLE, LFSR = LFSR_SEED.
  - All outputs are 0, including oRdNum.
- Storage: NCELLS entries of 5 bits each; value 0 = empty. oPressNum and oRdNum zero-extend to 6 bits.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle after reset, regardless of state.
  - Candidate cell = LFSR[log2(NCELLS)-1:0].
- Placement FSM has four states: IDLE, PICK, PROBE, WRITE.
  - IDLE: on iPlace with oFull low, go to PICK. iPlace with oFull high is ignored: no pulse, no state change.
  - PICK: latch the candidate, go to PROBE.
  - PROBE: if cell[cand]==0, go to WRITE. Otherwise cand = (cand+1) mod NCELLS and stay in PROBE. The probe terminates within NCELLS cycles because a free cell always exists.
  - WRITE: cell[cand] = count+1, count++, oPlaceDone=1 for this cycle, return to IDLE.
  - Latency from iPlace to oPlaceDone is 3 to 3+NCELLS-1 cycles.
- Selection (IDLE only):
  - iSelect samples cell[iCursor]. On the next cycle, oPressNum = that value for exactly one cycle, and the cell is cleared to 0 in the same cycle (tile removed).
  - Empty cell: oPressNum stays 0, no change.
  - iSelect while oBusy is ignored.
  - iCursor >= NCELLS is ignored.
- Simultaneous events:
  - iClear beats everything: on the next edge, cells=0, count=0, FSM=IDLE, any in-flight placement is aborted with no oPlaceDone, and any pending oPressNum is suppressed.
  - iPlace together with iSelect in IDLE: the placement is taken, the select is dropped.
- oRdNum returns the pre-write value if iRdCell is written in the same cycle.
- oTileCount does not decrement on select; only iClear resets it.

Optional Feature:
- Macro: CHIMP_BOARD_MASK_EN.
- Defined:
  - Adds an internal masked flag. It sets on the first oPressNum pulse with value 1 and clears on iClear or reset.
  - While masked, oRdNum reports every nonzero cell as 6'd63 (blank tile face). Empty cells still read 0.
  - oPressNum always carries the true number.
- Undefined: no flag; oRdNum always reports true numbers.

Decomposition:
- Shared package chimp_pkg holds:
  - The 6-bit tile-number width and the empty code 0.
  - The masked code 6'd63.
  - MAX_TILES.
  - The placement FSM state encoding.
- One sub-module, chimp_lfsr16: seed parameter, free-running, 16-bit output. The control FSM's testbench reuses it.

Test Plan:
- Reset then 3× iPlace (waiting for each oPlaceDone) -> oTileCount=3; a sweep of oRdNum over 32 cells shows exactly one each of 1, 2, 3 and 29 zeros.
- Force two placements to collide (same LFSR phase) -> second tile lands at cand+1 mod 32, including wrap from 31 to 0.
- iSelect on the cell holding 1 -> oPressNum=6'd1 for one cycle the next cycle; that cell then reads 0. iSelect on an empty cell -> oPressNum remains 0.
- 31 placements -> oFull=1; a further iPlace gives no oPlaceDone and oBusy stays 0.
- iClear asserted during PROBE -> no oPlaceDone, all cells 0, count 0, IDLE next cycle; iPlace together with iSelect -> placement only.
- With CHIMP_BOARD_MASK_EN: place 4, select tile 1 -> oRdNum reads 63 for the three remaining cells; without the macro it reads 2, 3, 4.
